// File: rtl/branch_resolver_pkg.sv
// Types shared between the fetch-side predictor and the execute-side branch resolver.
package branch_resolver_pkg;
    localparam int PC_WIDTH        = 32;
    localparam int PHT_INDEX_WIDTH = 4;

    typedef logic [PC_WIDTH-1:0] Pc;
    typedef logic [1:0]          PhtCounter;

    localparam PhtCounter PHT_COUNTER_MAX = 2'd3;
    localparam PhtCounter PHT_COUNTER_MIN = 2'd0;

    typedef struct packed {
        logic                       isBranchTakenPredicted;
        logic                       isNextPcPredicted;
        Pc                          predictedNextPC;
        logic [PHT_INDEX_WIDTH-1:0] globalBranchHistory;
    } BranchPredict;

    typedef struct packed {
        Pc            pc;
        logic         taken;
        Pc            target;
        BranchPredict predict;
    } BranchResolveInfo;
endpackage

// File: rtl/branch_resolver_pht_counter_update.sv
// Saturating 2-bit counter next-value logic for the pattern history table.
module pht_counter_update
    import branch_resolver_pkg::*;
(
    input  PhtCounter current_value,
    input  logic      taken,
    output PhtCounter next_value
);
    always_comb begin
        next_value = current_value;
        if (taken) begin
            if (current_value != PHT_COUNTER_MAX) next_value = current_value + 2'd1;
        end else if (current_value != PHT_COUNTER_MIN) begin
            next_value = current_value - 2'd1;
        end
    end
endmodule

// File: rtl/branch_resolver.sv
// Resolves branches against their fetch prediction: redirects on a miss, trains the PHT
// (read-modify-write with forwarding), writes the BTB and restores the global history.
module branch_resolver #(
    parameter int PHT_INDEX_WIDTH = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             resolveValid,
    input  logic                             resolveIsBranch,
    input  branch_resolver_pkg::Pc           resolvePc,
    input  logic                             resolveTaken,
    input  branch_resolver_pkg::Pc           resolveTarget,
    input  branch_resolver_pkg::BranchPredict resolvePredict,
    output logic [PHT_INDEX_WIDTH-1:0]       phtReadIndex,
    input  logic [1:0]                       phtReadData,
    output logic                             phtWe,
    output logic [PHT_INDEX_WIDTH-1:0]       phtWriteIndex,
    output logic [1:0]                       phtWriteData,
    output logic                             btbWe,
    output branch_resolver_pkg::Pc           btbWritePc,
    output branch_resolver_pkg::Pc           btbWriteTarget,
    output logic                             redirectValid,
    output branch_resolver_pkg::Pc           redirectPc,
    output logic                             ghrRestoreValid,
    output logic [PHT_INDEX_WIDTH-1:0]       ghrRestore,
    output logic [CNT_WIDTH-1:0]             branchCount,
    output logic [CNT_WIDTH-1:0]             mispredictCount
);
    import branch_resolver_pkg::*;

    localparam int IW = PHT_INDEX_WIDTH;

    BranchResolveInfo resolve_info;
    logic             capture;
    logic [IW-1:0]    index_in;
    logic             direction_miss;
    logic             target_miss;
    logic             need_redirect;

    assign resolve_info = '{pc: resolvePc, taken: resolveTaken, target: resolveTarget,
                            predict: resolvePredict};

    // A resolve seen while a redirect is out is on the wrong path and is ignored entirely.
    assign capture  = resolveValid && resolveIsBranch && !redirectValid;
    assign index_in = resolve_info.pc[IW+1:2] ^ resolve_info.predict.globalBranchHistory[IW-1:0];
    assign phtReadIndex = index_in;

    assign direction_miss = resolve_info.predict.isBranchTakenPredicted != resolve_info.taken;
    assign target_miss    = resolve_info.taken && resolve_info.predict.isBranchTakenPredicted &&
                            (!resolve_info.predict.isNextPcPredicted ||
                             resolve_info.predict.predictedNextPC != resolve_info.target);
    assign need_redirect  = direction_miss || target_miss;

    logic          s1_valid;
    logic          s1_taken;
    logic [IW-1:0] s1_index;
    logic          fwd_valid;
    logic [IW-1:0] fwd_index;
    PhtCounter     fwd_data;
    PhtCounter     counter_in;
    PhtCounter     counter_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            s1_taken        <= 1'b0;
            s1_index        <= '0;
            redirectValid   <= 1'b0;
            redirectPc      <= '0;
            ghrRestoreValid <= 1'b0;
            ghrRestore      <= '0;
            btbWe           <= 1'b0;
            btbWritePc      <= '0;
            btbWriteTarget  <= '0;
            branchCount     <= '0;
            mispredictCount <= '0;
            fwd_valid       <= 1'b0;
            fwd_index       <= '0;
            fwd_data        <= '0;
        end else begin
            s1_valid        <= capture;
            redirectValid   <= capture && need_redirect;
            ghrRestoreValid <= capture && need_redirect;
            btbWe           <= capture && resolve_info.taken;
            if (capture) begin
                s1_taken    <= resolve_info.taken;
                s1_index    <= index_in;
                branchCount <= branchCount + CNT_WIDTH'(1);
            end
            if (capture && direction_miss)
                mispredictCount <= mispredictCount + CNT_WIDTH'(1);
            if (capture && need_redirect) begin
                redirectPc <= resolve_info.taken ? resolve_info.target
                                                 : resolve_info.pc + PC_WIDTH'(4);
                ghrRestore <= {resolve_info.predict.globalBranchHistory[IW-2:0], resolve_info.taken};
            end
            if (capture && resolve_info.taken) begin
                btbWritePc     <= resolve_info.pc;
                btbWriteTarget <= resolve_info.target;
            end
            // The RAM read for S1 was issued before last cycle's write landed, so remember that write.
            fwd_valid <= phtWe;
            fwd_index <= phtWriteIndex;
            fwd_data  <= phtWriteData;
        end
    end

    assign counter_in = (fwd_valid && fwd_index == s1_index) ? fwd_data : phtReadData;

    pht_counter_update u_counter_update (
        .current_value (counter_in),
        .taken         (s1_taken),
        .next_value    (counter_next)
    );

    assign phtWe         = s1_valid;
    assign phtWriteIndex = s1_valid ? s1_index : '0;
    assign phtWriteData  = s1_valid ? counter_next : '0;
endmodule
